// File: rtl/hex_keypad_entry_pkg.sv
// Purpose : shared types and constants for the hex keypad entry block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: kp_state_t scan FSM states, KEY_MAP {row,col} -> hex code, MAX_DIGITS.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } kp_state_t;

  // Indexed {row, col}; row 3 carries '*' -> E and '#' -> F.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  localparam int MAX_DIGITS = 8;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/hex_keypad_entry_if.sv
// Purpose : bundles the keypad pins and the entry-value outputs of hex_keypad_entry.
// Latency : n/a (wires only).
// Backpressure: none; key_valid is a fire-and-forget pulse.
// Ports: kp_row/clear towards the block, kp_col/val/key_valid/key_code/digit_count from it.
interface hex_keypad_entry_if;
  logic [3:0]  kp_row;
  logic [3:0]  kp_col;
  logic        clear;
  logic [31:0] val;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [3:0]  digit_count;

  // master: the board/host side; slave: the keypad entry block.
  modport master (
    output kp_row, clear,
    input  kp_col, val, key_valid, key_code, digit_count
  );

  modport slave (
    input  kp_row, clear,
    output kp_col, val, key_valid, key_code, digit_count
  );
endinterface

// File: rtl/hex_keypad_entry_sync_2ff.sv
// Purpose : WIDTH-bit two-flop synchronizer, resets to all-ones (idle keypad rows).
// Latency : 2 clk cycles.
// Backpressure: none.
// Ports: clk, rst (async active-high), d_i asynchronous input, q_o synchronized output.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hex_keypad_entry.sv
// Purpose : scans a 4x4 keypad, debounces presses/releases, shifts accepted keys into a 32-bit value.
// Latency : key_valid one cycle after the DEBOUNCE_SCANS-th tick following detection (+2 sync cycles).
// Backpressure: none; keys are accepted unconditionally, clear overrides val/digit_count.
// Ports: clk, rst (async active-high), kp (hex_keypad_entry_if.slave: keypad pins and entry outputs).
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic               clk,
  input logic               rst,
  hex_keypad_entry_if.slave kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1) + 1;

  logic [3:0]    row_s;
  logic [DW-1:0] div_q;
  logic          tick;
  kp_state_t     state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    low_row;
  logic          row_lo;
  logic          advance;
  logic          commit;
  logic [3:0]    code;
  logic [31:0]   val_q, val_d;
  logic [3:0]    digits_q, digits_d;
  logic          key_valid_q;
  logic [3:0]    key_code_q;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.kp_row),
    .q_o (row_s)
  );

  assign tick = (div_q == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    low_row = 2'd3;
    if      (!row_s[0]) low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
  end

  assign row_lo = ~row_s[row_q];
  // col_q is frozen outside SCAN, so it doubles as the latched column.
  assign code   = key_lookup(row_q, col_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    advance = 1'b0;
    commit  = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_s != 4'hF) begin
            row_d   = low_row;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_lo) begin
            if (cnt_q >= CW'(DEBOUNCE_SCANS)) begin
              commit  = 1'b1;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = SCAN;
            advance = 1'b1;
          end
        end
        HELD: begin
          if (!row_lo) begin
            cnt_d   = CW'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (!row_lo) begin
            if (cnt_q >= CW'(DEBOUNCE_SCANS)) begin
              state_d = SCAN;
              advance = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign col_d = advance ? col_q + 1'b1 : col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  // clear beats a same-cycle commit for the value, but the key event itself still reports.
  always_comb begin
    val_d    = val_q;
    digits_d = digits_q;
    if (kp.clear) begin
      val_d    = '0;
      digits_d = '0;
    end else if (commit) begin
      val_d = {val_q[27:0], code};
      if (digits_q < 4'(MAX_DIGITS)) digits_d = digits_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q       <= '0;
      digits_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      val_q       <= val_d;
      digits_q    <= digits_d;
      key_valid_q <= commit;
      if (commit) key_code_q <= code;
    end
  end

  assign kp.kp_col      = ~(4'b0001 << col_q);
  assign kp.val         = val_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_code    = key_code_q;
  assign kp.digit_count = digits_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Purpose : self-checking bench for hex_keypad_entry with a simulated key matrix and a run-length reference model.
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_hex_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_keypad_entry_if bus();

  hex_keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] pressed;   // physical keys held, index row*4+col
  bit          clr;
  int          kv_pulses;
  string       keys = "123A456B789CE0FD";

  // reference model state (values as seen just after a clock edge)
  int          m_div, m_col, lrow, run;
  bit          locked, accepted;
  logic [3:0]  m_s1, m_s2;
  logic [31:0] m_val;
  int          m_cnt;
  bit          m_kv;
  logic [3:0]  m_kc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] hexval(input byte ch);
    if (ch >= "0" && ch <= "9") return 4'(ch - "0");
    return 4'(ch - "A" + 10);
  endfunction

  function automatic logic [3:0] rows_now(input logic [15:0] p, input logic [3:0] col);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (p[rr*4+cc] && !col[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_div = 0; m_col = 0; lrow = 0; run = 0;
    locked = 0; accepted = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_val = '0; m_cnt = 0; m_kv = 0; m_kc = '0;
  endtask

  // One clock edge: rin/c are what the bench drove during the cycle before it.
  task automatic model_step(input logic [3:0] rin, input bit c);
    bit         tick;
    bit         commit;
    logic [3:0] rs;
    logic [3:0] code;
    int         lr;
    tick   = (m_div == SCAN_DIV - 1);
    rs     = m_s2;
    commit = 0;
    code   = '0;
    if (tick) begin
      if (!locked) begin
        if (rs != 4'hF) begin
          lr = 0;
          for (int r = 3; r >= 0; r--) if (!rs[r]) lr = r;
          locked = 1; accepted = 0; lrow = lr; run = 1;
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end else if (!accepted) begin
        if (!rs[lrow]) begin
          if (run == DB) begin
            commit = 1; accepted = 1; run = 0;
            code = hexval(keys[lrow*4 + m_col]);
          end else run++;
        end else begin
          locked = 0; m_col = (m_col + 1) % 4;
        end
      end else begin
        // run counts consecutive high ticks of the held key
        if (rs[lrow]) begin
          run++;
          if (run == DB + 1) begin
            locked = 0; accepted = 0; run = 0;
            m_col = (m_col + 1) % 4;
          end
        end else run = 0;
      end
    end
    m_kv = commit;
    if (commit) m_kc = code;
    if (c) begin
      m_val = '0; m_cnt = 0;
    end else if (commit) begin
      m_val = (m_val << 4) | {28'd0, code};
      m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
    end
    m_s2  = m_s1;
    m_s1  = rin;
    m_div = (m_div + 1) % SCAN_DIV;
  endtask

  function automatic bit commit_next();
    return (m_div == SCAN_DIV - 1) && locked && !accepted && !m_s2[lrow] && (run == DB);
  endfunction

  task automatic compare_all();
    logic [3:0] ecol;
    ecol = ~(4'b0001 << m_col);
    check("kp_col", {28'd0, bus.kp_col}, {28'd0, ecol});
    check("val", bus.val, m_val);
    check("key_valid", {31'd0, bus.key_valid}, {31'd0, m_kv});
    check("key_code", {28'd0, bus.key_code}, {28'd0, m_kc});
    check("digit_count", {28'd0, bus.digit_count}, 32'(m_cnt));
  endtask

  task automatic cyc();
    logic [3:0] rin;
    bit         c;
    rin = rows_now(pressed, bus.kp_col);
    c   = clr;
    bus.kp_row = rin;
    bus.clear  = c;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_step(rin, c);
    if (bus.key_valid) kv_pulses++;
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic enter_key(input int idx);
    pressed[idx] = 1'b1;
    cycles(48);
    pressed = '0;
    cycles(40);
  endtask

  task automatic wait_kv(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (bus.key_valid) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s actual=timeout required=key_valid", name); end
  endtask

  task automatic wait_locked(input int budget, input int runs, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (locked && !accepted && run >= runs) begin ok = 1; break; end
      cyc();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s actual=timeout required=detect", name); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c0;
    logic [3:0] crot;
    bit         ok;
    pressed = '0; clr = 0;
    bus.kp_row = 4'hF; bus.clear = 1'b0;
    model_reset();
    cycles(2);
    check("rst_kp_col", {28'd0, bus.kp_col}, 32'h0000000E);
    check("rst_val", bus.val, 32'h0);
    check("rst_key_valid", {31'd0, bus.key_valid}, 32'h0);
    check("rst_key_code", {28'd0, bus.key_code}, 32'h0);
    check("rst_digit_count", {28'd0, bus.digit_count}, 32'h0);
    rst = 1'b0;

    // 1. idle scanning: column moves on every 4th edge
    kv_pulses = 0;
    cycles(3);
    check("idle_col0", {28'd0, bus.kp_col}, 32'h0000000E);
    cycles(1);
    check("idle_col1", {28'd0, bus.kp_col}, 32'h0000000D);
    cycles(4);
    check("idle_col2", {28'd0, bus.kp_col}, 32'h0000000B);
    cycles(4);
    check("idle_col3", {28'd0, bus.kp_col}, 32'h00000007);
    cycles(4);
    check("idle_wrap", {28'd0, bus.kp_col}, 32'h0000000E);
    cycles(48);
    check("idle_pulses", 32'(kv_pulses), 32'd0);
    check("idle_val", bus.val, 32'h0);

    // 2. single key "6"
    kv_pulses = 0;
    pressed[1*4+2] = 1'b1;
    wait_kv(64, "key6_detect");
    check("key6_code", {28'd0, bus.key_code}, 32'h6);
    cycles(40);
    pressed = '0;
    cycles(40);
    check("key6_pulses", 32'(kv_pulses), 32'd1);
    check("key6_val", bus.val, 32'h00000006);
    check("key6_count", {28'd0, bus.digit_count}, 32'd1);

    // 3. nine more digits, count saturates
    enter_key(0); enter_key(1); enter_key(2); enter_key(3);
    enter_key(4); enter_key(5); enter_key(6); enter_key(7);
    enter_key(8);
    check("seq_val", bus.val, 32'h23A456B7);
    check("seq_count", {28'd0, bus.digit_count}, 32'd8);

    // 4. bounce: two low ticks only
    kv_pulses = 0;
    pressed[0] = 1'b1;
    wait_locked(64, 2, "bounce_detect");
    pressed = '0;
    cycles(24);
    check("bounce_pulses", 32'(kv_pulses), 32'd0);
    check("bounce_val", bus.val, 32'h23A456B7);
    c0 = bus.kp_col;
    crot = {c0[2:0], c0[3]};
    cycles(SCAN_DIV);
    check("bounce_rescan", {28'd0, bus.kp_col}, {28'd0, crot});

    // 5. two rows on column 0, then a second key while held
    kv_pulses = 0;
    pressed[3*4+0] = 1'b1;
    pressed[2*4+0] = 1'b1;
    wait_kv(64, "multi_detect");
    check("multi_code", {28'd0, bus.key_code}, 32'h7);
    pressed[3*4+1] = 1'b1;
    cycles(40);
    check("multi_pulses", 32'(kv_pulses), 32'd1);
    check("multi_val", bus.val, 32'h3A456B77);
    pressed = '0;
    cycles(40);

    // 6a. clear in the commit cycle of "F"
    pressed[3*4+2] = 1'b1;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      if (commit_next()) begin ok = 1; break; end
      cyc();
    end
    check("clearF_reach", {31'd0, ok}, 32'd1);
    clr = 1; cyc(); clr = 0;
    check("clearF_val", bus.val, 32'h0);
    check("clearF_count", {28'd0, bus.digit_count}, 32'd0);
    check("clearF_kv", {31'd0, bus.key_valid}, 32'd1);
    check("clearF_code", {28'd0, bus.key_code}, 32'hF);
    pressed = '0;
    cycles(40);
    enter_key(9);
    check("post_clear_val", bus.val, 32'h00000008);

    // 6b. reset while debouncing "5", key held through reset release
    pressed[1*4+1] = 1'b1;
    wait_locked(64, 1, "rst_detect");
    rst = 1'b1;
    #1;
    check("mid_rst_col", {28'd0, bus.kp_col}, 32'h0000000E);
    check("mid_rst_val", bus.val, 32'h0);
    check("mid_rst_kv", {31'd0, bus.key_valid}, 32'h0);
    check("mid_rst_code", {28'd0, bus.key_code}, 32'h0);
    check("mid_rst_count", {28'd0, bus.digit_count}, 32'h0);
    model_reset();
    cycles(2);
    rst = 1'b0;
    wait_kv(80, "rst_redetect");
    check("redetect_code", {28'd0, bus.key_code}, 32'h5);
    check("redetect_val", bus.val, 32'h00000005);
    pressed = '0;
    cycles(40);

    // random presses, bounces, overlapping keys and clears
    for (int n = 0; n < 60; n++) begin
      int k, hold, gap;
      k    = $urandom_range(0, 15);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : $urandom_range(30, 70);
      gap  = $urandom_range(5, 50);
      pressed[k] = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 40) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
        clr = ($urandom_range(0, 63) == 0);
        cyc();
        clr = 0;
      end
      pressed = '0;
      cycles(gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
- Input-side counterpart of the board's hex display path.
- Scans a 4x4 matrix keypad and debounces key presses.
- Each accepted key is shifted as a hex nibble into a 32-bit entry value, which feeds the 8-digit seven-segment display and is readable by the core.
- Sits at board-I/O level, between the keypad pins and the memory-mapped I/O register.

Parameters:
- SCAN_DIV, 50000: clk cycles per column dwell / sample tick; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive matching ticks required to accept a press or a release; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- kp_row  in  4  keypad row sense, active-low with external pull-ups, asynchronous to clk
- kp_col  out  4  keypad column drive, active-low; exactly one bit low at all times
- clear  in  1  synchronous request: zero val and digit_count
- val  out  32  entered value; newest digit in [3:0]
- key_valid  out  1  one-cycle pulse when a key is accepted
- key_code  out  4  code of the last accepted key
- digit_count  out  4  digits entered since reset/clear, saturates at 8

Behaviour:
- Reset values: kp_col=4'b1110 (column 0); val=0; key_valid=0; key_code=0; digit_count=0; FSM=SCAN; divider=0; debounce count=0.
- kp_row passes through a 2-flop synchronizer; row_s is the synchronized copy. All decisions use row_s.
- Divider counts 0..SCAN_DIV-1 and wraps. tick is high in the cycle the divider equals SCAN_DIV-1.
- Key map, row r / column c, with r selecting a group and c indexing within it:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D (* maps to E, # maps to F)
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
  - SCAN, on tick:
    - If row_s != 4'hF: latch the current column and the lowest-index low row, set debounce count=1, go to DEBOUNCE. The column is not advanced.
    - Otherwise rotate kp_col to the next column (3 wraps to 0).
  - DEBOUNCE, on tick:
    - If the latched row bit is still low: count++.
    - When the count reaches DEBOUNCE_SCANS: commit, go to HELD.
    - If the latched row bit is high: go to SCAN and advance the column.
    - With DEBOUNCE_SCANS=1, commit happens on the tick after entry.
  - Commit (single cycle):
    - key_valid=1, key_code=mapped code.
    - val <= {val[27:0], code}.
    - digit_count <= min(digit_count+1, 8).
    - Digits shifted out of val[31:28] are discarded.
  - HELD: column stays driven; no further commits. On tick with the latched row high: count=1, go to RELEASE.
  - RELEASE, on tick:
    - Latched row high: count++.
    - Reaching DEBOUNCE_SCANS: go to SCAN and advance the column.
    - Latched row low again: back to HELD.
- Keys pressed on other rows/columns during DEBOUNCE, HELD or RELEASE are ignored; there is no rollover or repeat.
- clear: val=0 and digit_count=0 next cycle. clear wins over a commit in the same cycle, but key_valid/key_code still update. clear does not affect FSM state or kp_col.
- Latency: key stable from tick T gives key_valid at tick T+DEBOUNCE_SCANS (plus 2-cycle sync skew on the first sample).
- Mid-operation rst: all state returns to reset values immediately. A key held through reset release must be re-detected from SCAN and counts as a new press.

Decomposition:
- Package keypad_pkg holds:
  - kp_state_t enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - KEY_MAP constant, a 16-entry 4-bit array indexed {row, col}
  - MAX_DIGITS=8
- One sub-module: sync_2ff, a parameterizable-width 2-flop synchronizer with async active-high reset to all-ones (idle keypad).

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Reset then idle 64 cycles -> kp_col cycles 1110, 1101, 1011, 0111, 1110…, changing every 4 cycles; key_valid never pulses; val=0.
2. Press row1/col2 ("6") held 40 cycles, then release -> exactly one key_valid; key_code=4'h6; val=32'h00000006; digit_count=1; scanning resumes after 3 high ticks.
3. Enter 1,2,3,A,4,5,6,B,7 -> val=32'h23A456B7; digit_count=8 (saturated).
4. Row0/col0 low for 2 ticks, then high (bounce) -> no key_valid; FSM back in SCAN; val unchanged.
5. Row3/col0 and row2/col0 low together -> key_code=4'h7 (row2, lowest row wins); while "7" is held, press "0" -> no second commit.
6. Assert clear in the commit cycle of "F" -> val=0, digit_count=0, key_valid=1, key_code=4'hF. Separately, rst mid-DEBOUNCE -> kp_col=4'b1110 and all outputs 0 immediately.
